// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between two valid/ready write
// masters. Round-robin grants with bounded bursts; the write controls driven
// into the register file are registered one cycle after each transfer.
//
// Ports:
//   Clk, rst_n             clock, synchronous active-low reset
//   m0_valid/addr/data/last  master 0 request, m0_ready accept
//   m1_valid/addr/data/last  master 1 request, m1_ready accept
//   WEN, RW, busW          registered register-file write port
//   owner                  00 none, 01 master 0, 10 master 1
//   wr_count               forwarded writes since reset, 8-bit wrapping
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid masters
// GRANT0 | master 0 owns the write port
// GRANT1 | master 1 owns the write port

module regfile_write_arbiter #(
   parameter int DW        = 8,
   parameter int AW        = 3,
   parameter int MAX_BURST = 4
) (
   input  logic          Clk,
   input  logic          rst_n,
   input  logic          m0_valid,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_data,
   input  logic          m0_last,
   output logic          m0_ready,
   input  logic          m1_valid,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_data,
   input  logic          m1_last,
   output logic          m1_ready,
   output logic          WEN,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] busW,
   output logic [1:0]    owner,
   output logic [7:0]    wr_count
);

   localparam int BCW = $clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   state_t         state, state_nxt;
   logic           prefer_m1, prefer_m1_nxt;
   logic [BCW-1:0] burst_cnt, burst_cnt_nxt;

   logic           xfer;
   logic [AW-1:0]  xfer_addr;
   logic [DW-1:0]  xfer_data;
   logic           xfer_last;
   logic           grant_exit;

   assign m0_ready = (state == GRANT0);
   assign m1_ready = (state == GRANT1);
   assign owner    = state;

   // Only the granted master can complete a handshake.
   always_comb begin
      xfer      = 1'b0;
      xfer_addr = m0_addr;
      xfer_data = m0_data;
      xfer_last = m0_last;
      case (state)
         GRANT0: xfer = m0_valid;
         GRANT1: begin
            xfer      = m1_valid;
            xfer_addr = m1_addr;
            xfer_data = m1_data;
            xfer_last = m1_last;
         end
         default: xfer = 1'b0;
      endcase
   end

   // A grant ends on last, on the burst limit, or when the owner goes idle.
   assign grant_exit = !xfer || xfer_last || (burst_cnt == BURST_LAST);

   always_comb begin
      state_nxt     = state;
      prefer_m1_nxt = prefer_m1;
      burst_cnt_nxt = burst_cnt;
      case (state)
         IDLE: begin
            if (m0_valid && m1_valid)
               state_nxt = prefer_m1 ? GRANT1 : GRANT0;
            else if (m0_valid)
               state_nxt = GRANT0;
            else if (m1_valid)
               state_nxt = GRANT1;
         end
         GRANT0: begin
            if (xfer)
               burst_cnt_nxt = burst_cnt + 1'b1;
            if (grant_exit) begin
               prefer_m1_nxt = 1'b1;
               burst_cnt_nxt = '0;
               state_nxt     = m1_valid ? GRANT1 : IDLE;
            end
         end
         GRANT1: begin
            if (xfer)
               burst_cnt_nxt = burst_cnt + 1'b1;
            if (grant_exit) begin
               prefer_m1_nxt = 1'b0;
               burst_cnt_nxt = '0;
               state_nxt     = m0_valid ? GRANT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         prefer_m1 <= 1'b0;
         burst_cnt <= '0;
         WEN       <= 1'b0;
         RW        <= '0;
         busW      <= '0;
         wr_count  <= '0;
      end else begin
         state     <= state_nxt;
         prefer_m1 <= prefer_m1_nxt;
         burst_cnt <= burst_cnt_nxt;
         // Address 0 is the hard-wired zero register: accept but never write.
         WEN       <= xfer && (xfer_addr != '0);
         if (xfer) begin
            RW   <= xfer_addr;
            busW <= xfer_data;
         end
         if (xfer && (xfer_addr != '0))
            wr_count <= wr_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Master queues model the two
// write masters; expected register-file writes are queued in the order the
// arbitration rules dictate and popped whenever WEN is seen.

module tb_regfile_write_arbiter;

   typedef struct {
      logic [2:0] addr;
      logic [7:0] data;
      logic       last;
   } req_t;

   logic       Clk;
   logic       rst_n;
   logic       m0_valid, m0_last, m0_ready;
   logic [2:0] m0_addr;
   logic [7:0] m0_data;
   logic       m1_valid, m1_last, m1_ready;
   logic [2:0] m1_addr;
   logic [7:0] m1_data;
   logic       WEN;
   logic [2:0] RW;
   logic [7:0] busW;
   logic [1:0] owner;
   logic [7:0] wr_count;

   req_t        q0[$];
   req_t        q1[$];
   logic [10:0] exp_q[$];
   logic [7:0]  model_cnt;
   int          checks;
   int          errors;
   int          writes_seen;

   regfile_write_arbiter #(.DW(8), .AW(3), .MAX_BURST(4)) dut (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .m0_valid (m0_valid),
      .m0_addr  (m0_addr),
      .m0_data  (m0_data),
      .m0_last  (m0_last),
      .m0_ready (m0_ready),
      .m1_valid (m1_valid),
      .m1_addr  (m1_addr),
      .m1_data  (m1_data),
      .m1_last  (m1_last),
      .m1_ready (m1_ready),
      .WEN      (WEN),
      .RW       (RW),
      .busW     (busW),
      .owner    (owner),
      .wr_count (wr_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      if (q0.size() > 0) begin
         m0_valid = 1'b1;
         m0_addr  = q0[0].addr;
         m0_data  = q0[0].data;
         m0_last  = q0[0].last;
      end else begin
         m0_valid = 1'b0;
         m0_addr  = '0;
         m0_data  = '0;
         m0_last  = 1'b0;
      end
      if (q1.size() > 0) begin
         m1_valid = 1'b1;
         m1_addr  = q1[0].addr;
         m1_data  = q1[0].data;
         m1_last  = q1[0].last;
      end else begin
         m1_valid = 1'b0;
         m1_addr  = '0;
         m1_data  = '0;
         m1_last  = 1'b0;
      end
   endtask

   task automatic put0(input logic [2:0] a, input logic [7:0] d, input logic l);
      req_t r;
      r.addr = a; r.data = d; r.last = l;
      q0.push_back(r);
   endtask

   task automatic put1(input logic [2:0] a, input logic [7:0] d, input logic l);
      req_t r;
      r.addr = a; r.data = d; r.last = l;
      q1.push_back(r);
   endtask

   task automatic expw(input logic [2:0] a, input logic [7:0] d);
      if (a != 3'd0) begin
         exp_q.push_back({a, d});
         model_cnt = model_cnt + 8'd1;
      end
   endtask

   // One clock: observe the write port and handshakes before the edge,
   // then retire accepted requests and present the next ones after it.
   task automatic tick();
      logic        hs0, hs1, rs;
      logic [10:0] e;
      @(negedge Clk);
      rs  = rst_n;
      hs0 = m0_valid && m0_ready && rs;
      hs1 = m1_valid && m1_ready && rs;
      if (WEN === 1'b1) begin
         writes_seen++;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = 'x;
         check("write_port", {21'd0, RW, busW}, {21'd0, e});
      end
      @(posedge Clk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      drive();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      writes_seen = 0;
      model_cnt   = 8'd0;
      rst_n       = 1'b0;

      // Reset with both masters requesting, then single writes.
      put0(3'd3, 8'hA5, 1'b1);
      put1(3'd5, 8'h5A, 1'b1);
      expw(3'd3, 8'hA5);
      expw(3'd5, 8'h5A);
      drive();
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_wen", {31'd0, WEN}, 32'd0);
         check("rst_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
         check("rst_owner", {30'd0, owner}, 32'd0);
         check("rst_wr_count", {24'd0, wr_count}, 32'd0);
      end
      rst_n = 1'b1;
      tick();
      check("arb_latency_ready", {30'd0, m0_ready, m1_ready}, 32'b10);
      check("arb_latency_owner", {30'd0, owner}, 32'd1);
      tick();
      check("handoff_owner", {30'd0, owner}, 32'd2);
      check("single_wen", {31'd0, WEN}, 32'd1);
      check("single_wr_count", {24'd0, wr_count}, 32'd1);
      tick();
      check("back_idle_owner", {30'd0, owner}, 32'd0);
      ticks(3);
      check("single_drain", exp_q.size(), 32'd0);
      check("single_count", {24'd0, wr_count}, {24'd0, model_cnt});

      // Contention with last on every transfer: grants alternate each cycle.
      for (int i = 0; i < 4; i++) begin
         put0(3'(i + 1), 8'(8'h10 + i), 1'b1);
         put1(3'(i + 4), 8'(8'h20 + i), 1'b1);
         expw(3'(i + 1), 8'(8'h10 + i));
         expw(3'(i + 4), 8'(8'h20 + i));
      end
      drive();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("contention_owner", {30'd0, owner}, (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      ticks(4);
      check("contention_drain", exp_q.size(), 32'd0);
      check("contention_count", {24'd0, wr_count}, {24'd0, model_cnt});

      // Burst limit: m1 granted first, forced hand-off after four transfers.
      for (int i = 1; i <= 6; i++) put1(3'(i), 8'(8'h30 + i), (i == 6));
      drive();
      tick();
      check("burst_owner", {30'd0, owner}, 32'd2);
      put0(3'd7, 8'h77, 1'b1);
      drive();
      for (int i = 1; i <= 4; i++) expw(3'(i), 8'(8'h30 + i));
      expw(3'd7, 8'h77);
      expw(3'd5, 8'h35);
      expw(3'd6, 8'h36);
      ticks(12);
      check("burst_drain", exp_q.size(), 32'd0);
      check("burst_count", {24'd0, wr_count}, 32'd17);

      // Zero register: handshake completes but nothing is written.
      put0(3'd0, 8'hFF, 1'b1);
      drive();
      ticks(5);
      check("zero_accepted", q0.size(), 32'd0);
      check("zero_count", {24'd0, wr_count}, 32'd17);

      // Reset mid-burst: the transfer at the reset edge is dropped.
      put0(3'd1, 8'h41, 1'b0);
      put0(3'd2, 8'h42, 1'b0);
      put0(3'd3, 8'h43, 1'b0);
      put0(3'd4, 8'h44, 1'b1);
      expw(3'd1, 8'h41);
      drive();
      tick();
      check("midburst_grant", {31'd0, m0_ready}, 32'd1);
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_wen", {31'd0, WEN}, 32'd0);
      check("midrst_owner", {30'd0, owner}, 32'd0);
      check("midrst_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
      check("midrst_wr_count", {24'd0, wr_count}, 32'd0);
      q0.delete();
      q1.delete();
      model_cnt = 8'd0;
      drive();
      rst_n = 1'b1;
      tick();
      check("post_rst_wen", {31'd0, WEN}, 32'd0);
      check("midrst_drain", exp_q.size(), 32'd0);

      // 256 forwarded writes wrap the counter back to zero.
      writes_seen = 0;
      for (int i = 0; i < 256; i++) begin
         put0(3'((i % 7) + 1), 8'(i), 1'b1);
         expw(3'((i % 7) + 1), 8'(i));
      end
      drive();
      ticks(530);
      check("wrap_drain", exp_q.size(), 32'd0);
      check("wrap_writes", writes_seen, 32'd256);
      check("wrap_count", {24'd0, wr_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
